pio_write_arbiter: RTL

Round-robin arbiter and Avalon-MM write master that shares one 8-bit output PIO slave between N_REQ independent requesters. Each requester posts a write, set-bits or clear-bits operation with an 8-bit mask. The block serialises these operations into single-cycle PIO slave writes at address 0, 4 or 5. It keeps a shadow copy of the PIO output so that firmware-side logic can read the current port state without a bus read.

---
 rtl/pio_write_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter that turns per-requester write/set/clear operations into
// single-cycle Avalon-MM writes to an output PIO, keeping a shadow of the port.
module pio_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [2*N_REQ-1:0]      req_op,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [2:0]              avm_address,
  output logic                    avm_chipselect,
  output logic                    avm_write_n,
  output logic [31:0]             avm_writedata,
  output logic [DATA_W-1:0]       shadow,
  output logic                    busy
);
  // Handshake: requester i holds req[i] with a stable op/data until it sees a
  // one-cycle ack[i]; op/data are sampled only on the granting edge, and a req
  // still high once the arbiter is back in IDLE counts as a fresh request.

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  last_grant_q;
  logic [IDX_W-1:0]  grant_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [IDX_W:0]    scan_idx;

  logic [1:0]        op_arr   [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  logic [N_REQ-1:0]  ack_d;
  logic [2:0]        addr_d;
  logic              cs_d;
  logic              wn_d;
  logic [31:0]       wd_d;
  logic [DATA_W-1:0] shadow_d;
  logic              busy_d;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      op_arr[i]   = req_op[2*i +: 2];
      data_arr[i] = req_data[DATA_W*i +: DATA_W];
    end
  end

  // Scan starts just after the last granted requester and wraps, so the most
  // recently served requester has lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = {1'b0, last_grant_q} + (IDX_W+1)'(k);
      if (scan_idx >= (IDX_W+1)'(N_REQ)) scan_idx = scan_idx - (IDX_W+1)'(N_REQ);
      if (!pick_valid && req[scan_idx[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs: bus strobes are loaded on the
  // granting edge, shadow and ack on the edge that ends ISSUE.
  always_comb begin
    cs_d     = 1'b0;
    wn_d     = 1'b1;
    addr_d   = '0;
    wd_d     = '0;
    ack_d    = '0;
    shadow_d = shadow;
    busy_d   = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          case (op_arr[pick_idx])
            OP_WRITE: begin
              cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_DATA; wd_d = 32'(data_arr[pick_idx]);
            end
            OP_SET: begin
              cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_SET; wd_d = 32'(data_arr[pick_idx]);
            end
            OP_CLEAR: begin
              cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CLR; wd_d = 32'(data_arr[pick_idx]);
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        ack_d[grant_q] = 1'b1;
        case (op_q)
          OP_WRITE: shadow_d = data_q;
          OP_SET:   shadow_d = shadow | data_q;
          OP_CLEAR: shadow_d = shadow & ~data_q;
          default:  ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q      <= '0;
      op_q         <= OP_NOP;
      data_q       <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
    end else begin
      if (state_q == ST_IDLE && pick_valid) begin
        grant_q <= pick_idx;
        op_q    <= op_arr[pick_idx];
        data_q  <= data_arr[pick_idx];
      end
      if (state_q == ST_DONE) last_grant_q <= grant_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack            <= '0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      shadow         <= '0;
      busy           <= 1'b0;
    end else begin
      ack            <= ack_d;
      avm_address    <= addr_d;
      avm_chipselect <= cs_d;
      avm_write_n    <= wn_d;
      avm_writedata  <= wd_d;
      shadow         <= shadow_d;
      busy           <= busy_d;
    end
  end

endmodule
